unified_mem_arbiter: RTL and testbench

- Sits between the multi-cycle core and the single-port unified instruction/data memory: 32-bit words, combinational read, write on posedge clk.
- Arbitrates between two requesters: instruction fetch (IF) and load/store (LS).
- Converts byte addresses to word indices.
- Implements byte/halfword stores as a two-cycle read-modify-write (RMW).
- Enforces fetch anti-starvation.

---
 rtl/unified_mem_arbiter_if.sv | 41 ++++
 rtl/unified_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Request/response and memory-port bundle between the core requesters, the arbiter
// and the unified single-port memory.
interface unified_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_wstrb;
  logic        ls_gnt;
  logic        ls_valid;
  logic [31:0] ls_rdata;
  logic        ls_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [31:0] mem_rd;

  // Arbiter side: takes requests and memory read data, drives grants, responses and the memory port.
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb, mem_rd,
    output if_gnt, if_valid, if_rdata, if_err,
           ls_gnt, ls_valid, ls_rdata, ls_err,
           mem_addr, mem_din, mem_we
  );

  // Core/memory side: the mirror image of the arbiter.
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb, mem_rd,
    input  if_gnt, if_valid, if_rdata, if_err,
           ls_gnt, ls_valid, ls_rdata, ls_err,
           mem_addr, mem_din, mem_we
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbiter for the single-port unified memory: fetch vs load/store with fetch
// anti-starvation, byte-to-word addressing and read-modify-write partial stores.
module unified_mem_arbiter #(
  parameter int DEPTH_LOG2    = 10,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  unified_mem_arbiter_if.slave  bus
);

  localparam int SW = $clog2(MAX_LS_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

  typedef enum logic [0:0] {IDLE, RMW_WR} state_t;

  function automatic logic [31:0] word_idx(input logic [31:0] a);
    logic [31:0] w;
    w = '0;
    w[DEPTH_LOG2-1:0] = a[DEPTH_LOG2+1:2];
    return w;
  endfunction

  function automatic logic out_of_range(input logic [31:0] a);
    return |a[31:DEPTH_LOG2+2];
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++)
      m[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return m;
  endfunction

  state_t                state;
  logic [SW-1:0]         streak;

  logic                  if_vld_p1, if_err_p1, ls_vld_p1, ls_err_p1;
  logic [31:0]           if_rdata_p1, ls_rdata_p1;

  logic [DEPTH_LOG2-1:0] rmw_idx_p1;
  logic [31:0]           rmw_wdata_p1, rmw_old_p1;
  logic [3:0]            rmw_wstrb_p1;

  logic if_oor, ls_err_c, ls_partial;
  logic if_wins, if_gnt, ls_gnt;
  logic ls_full_wr, ls_rmw_start;
  logic unused_if_lane;

  assign unused_if_lane = ^bus.if_addr[1:0];

  assign if_oor     = out_of_range(bus.if_addr);
  assign ls_err_c   = out_of_range(bus.ls_addr) || (bus.ls_addr[1:0] != 2'b00);
  assign ls_partial = (bus.ls_wstrb != 4'h0) && (bus.ls_wstrb != 4'hF);

  // LS has priority; a fetch that has watched MAX_LS_STREAK LS grants go by is forced through.
  assign if_wins = bus.if_req && (!bus.ls_req || (streak >= STREAK_MAX));
  assign if_gnt  = (state == IDLE) && if_wins;
  assign ls_gnt  = (state == IDLE) && bus.ls_req && !if_wins;

  assign ls_full_wr   = ls_gnt && bus.ls_we && (bus.ls_wstrb == 4'hF) && !ls_err_c;
  assign ls_rmw_start = ls_gnt && bus.ls_we && ls_partial && !ls_err_c;

  assign bus.if_gnt   = if_gnt;
  assign bus.ls_gnt   = ls_gnt;
  assign bus.if_valid = if_vld_p1;
  assign bus.if_err   = if_err_p1;
  assign bus.if_rdata = if_rdata_p1;
  assign bus.ls_valid = ls_vld_p1;
  assign bus.ls_err   = ls_err_p1;
  assign bus.ls_rdata = ls_rdata_p1;

  always_comb begin
    bus.mem_we   = 1'b0;
    bus.mem_din  = bus.ls_wdata;
    bus.mem_addr = word_idx(bus.if_addr);
    if (state == RMW_WR) begin
      bus.mem_we   = 1'b1;
      bus.mem_addr = '0;
      bus.mem_addr[DEPTH_LOG2-1:0] = rmw_idx_p1;
      bus.mem_din  = merge_lanes(rmw_old_p1, rmw_wdata_p1, rmw_wstrb_p1);
    end else if (ls_gnt) begin
      bus.mem_addr = word_idx(bus.ls_addr);
      bus.mem_we   = ls_full_wr;
    end
  end

  // Stage p1: grant cycle -> registered response, or RMW merge state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      streak      <= '0;
      if_vld_p1   <= 1'b0;
      if_err_p1   <= 1'b0;
      if_rdata_p1 <= '0;
      ls_vld_p1   <= 1'b0;
      ls_err_p1   <= 1'b0;
      ls_rdata_p1 <= '0;
    end else begin
      if_vld_p1 <= 1'b0;
      if_err_p1 <= 1'b0;
      ls_vld_p1 <= 1'b0;
      ls_err_p1 <= 1'b0;

      if (if_gnt || !bus.if_req)
        streak <= '0;
      else if (ls_gnt && (streak < STREAK_MAX))
        streak <= streak + 1'b1;

      case (state)
        IDLE: begin
          if (if_gnt) begin
            if_vld_p1   <= 1'b1;
            if_err_p1   <= if_oor;
            if_rdata_p1 <= if_oor ? 32'h0 : bus.mem_rd;
          end
          if (ls_rmw_start) begin
            state <= RMW_WR;
          end else if (ls_gnt) begin
            ls_vld_p1   <= 1'b1;
            ls_err_p1   <= ls_err_c;
            ls_rdata_p1 <= (bus.ls_we || ls_err_c) ? 32'h0 : bus.mem_rd;
          end
        end
        RMW_WR: begin
          state       <= IDLE;
          ls_vld_p1   <= 1'b1;
          ls_rdata_p1 <= 32'h0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Partial-store context captured in the grant cycle; only meaningful while in RMW_WR.
  always_ff @(posedge clk) begin
    if (ls_rmw_start) begin
      rmw_idx_p1   <= bus.ls_addr[DEPTH_LOG2+1:2];
      rmw_wdata_p1 <= bus.ls_wdata;
      rmw_wstrb_p1 <= bus.ls_wstrb;
      rmw_old_p1   <= bus.mem_rd;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed per-cycle vector bench for unified_mem_arbiter with a behavioural memory.
module tb_unified_mem_arbiter;

  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  unified_mem_arbiter_if bus();

  unified_mem_arbiter #(.DEPTH_LOG2(10), .MAX_LS_STREAK(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [31:0] mem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  assign bus.mem_rd = mem[bus.mem_addr[9:0]];

  always @(posedge clk) begin
    if (bus.mem_we)  mem[bus.mem_addr[9:0]] <= bus.mem_din;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  typedef struct packed {
    logic        ifr;
    logic [31:0] ifa;
    logic        lsr;
    logic        we;
    logic [31:0] lsa;
    logic [31:0] wd;
    logic [3:0]  st;
    logic        e_ig;
    logic        e_lg;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_din;
    logic        e_iv;
    logic        e_ie;
    logic [31:0] e_ird;
    logic        e_lv;
    logic        e_le;
    logic [31:0] e_lrd;
  } vec_t;

  vec_t vq[$];
  int errors = 0;
  int checks = 0;

  function automatic vec_t mk(
    input logic ifr, input logic [31:0] ifa,
    input logic lsr, input logic we, input logic [31:0] lsa, input logic [31:0] wd, input logic [3:0] st,
    input logic e_ig, input logic e_lg, input logic e_we, input logic [31:0] e_addr, input logic [31:0] e_din,
    input logic e_iv, input logic e_ie, input logic [31:0] e_ird,
    input logic e_lv, input logic e_le, input logic [31:0] e_lrd);
    vec_t v;
    v.ifr = ifr; v.ifa = ifa; v.lsr = lsr; v.we = we; v.lsa = lsa; v.wd = wd; v.st = st;
    v.e_ig = e_ig; v.e_lg = e_lg; v.e_we = e_we; v.e_addr = e_addr; v.e_din = e_din;
    v.e_iv = e_iv; v.e_ie = e_ie; v.e_ird = e_ird;
    v.e_lv = e_lv; v.e_le = e_le; v.e_lrd = e_lrd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ifr, input logic [31:0] ifa, input logic lsr, input logic we,
                       input logic [31:0] lsa, input logic [31:0] wd, input logic [3:0] st);
    bus.if_req = ifr; bus.if_addr = ifa;
    bus.ls_req = lsr; bus.ls_we = we; bus.ls_addr = lsa; bus.ls_wdata = wd; bus.ls_wstrb = st;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive(v.ifr, v.ifa, v.lsr, v.we, v.lsa, v.wd, v.st);
    #1;
    chk($sformatf("v%0d if_gnt", idx), 32'(bus.if_gnt), 32'(v.e_ig));
    chk($sformatf("v%0d ls_gnt", idx), 32'(bus.ls_gnt), 32'(v.e_lg));
    chk($sformatf("v%0d mem_we", idx), 32'(bus.mem_we), 32'(v.e_we));
    if (v.e_ig || v.e_lg || v.e_we)
      chk($sformatf("v%0d mem_addr", idx), bus.mem_addr, v.e_addr);
    if (v.e_we)
      chk($sformatf("v%0d mem_din", idx), bus.mem_din, v.e_din);
    chk($sformatf("v%0d if_valid", idx), 32'(bus.if_valid), 32'(v.e_iv));
    chk($sformatf("v%0d if_err", idx), 32'(bus.if_err), 32'(v.e_ie));
    if (v.e_iv)
      chk($sformatf("v%0d if_rdata", idx), bus.if_rdata, v.e_ird);
    chk($sformatf("v%0d ls_valid", idx), 32'(bus.ls_valid), 32'(v.e_lv));
    chk($sformatf("v%0d ls_err", idx), 32'(bus.ls_err), 32'(v.e_le));
    if (v.e_lv)
      chk($sformatf("v%0d ls_rdata", idx), bus.ls_rdata, v.e_lrd);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vq.size(); i++) run_vec(vq[i], i);
    vq.delete();
    $display("table %s done", tag);
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(N, 32'h0, N, N, 32'h0, 32'h0, 4'h0);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " if_valid"}, 32'(bus.if_valid), 32'h0);
    chk({tag, " ls_valid"}, 32'(bus.ls_valid), 32'h0);
    chk({tag, " if_err"},   32'(bus.if_err),   32'h0);
    chk({tag, " ls_err"},   32'(bus.ls_err),   32'h0);
    chk({tag, " if_rdata"}, bus.if_rdata,      32'h0);
    chk({tag, " ls_rdata"}, bus.ls_rdata,      32'h0);
    chk({tag, " mem_we"},   32'(bus.mem_we),   32'h0);
  endtask

  initial begin
    logic exp_if;
    drive(N, 32'h0, N, N, 32'h0, 32'h0, 4'h0);

    // Reset state, then preload mem[0] for the first fetch.
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    rst_n = 1'b1;
    preload(10'd0, 32'h0020A1A3);

    // Fetch, full store, load back.
    vq.push_back(mk(Y,32'h0, N,N,32'h0,32'h0,4'h0,           Y,N,N,32'h0,32'h0,        N,N,32'h0,        N,N,32'h0));
    vq.push_back(mk(N,32'h0, N,N,32'h0,32'h0,4'h0,           N,N,N,32'h0,32'h0,        Y,N,32'h0020A1A3, N,N,32'h0));
    vq.push_back(mk(N,32'h0, Y,Y,32'h10,32'hDEADBEEF,4'hF,   N,Y,Y,32'h4,32'hDEADBEEF, N,N,32'h0,        N,N,32'h0));
    vq.push_back(mk(N,32'h0, N,N,32'h0,32'h0,4'h0,           N,N,N,32'h0,32'h0,        N,N,32'h0,        Y,N,32'h0));
    vq.push_back(mk(N,32'h0, Y,N,32'h10,32'h0,4'h0,          N,Y,N,32'h4,32'h0,        N,N,32'h0,        N,N,32'h0));
    vq.push_back(mk(N,32'h0, N,N,32'h0,32'h0,4'h0,           N,N,N,32'h0,32'h0,        N,N,32'h0,        Y,N,32'hDEADBEEF));
    run_table("basic");

    // Reset while a fetch response is showing: valids drop at once.
    @(negedge clk);
    drive(Y, 32'h0, N, N, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    chk("midrst pre if_valid", 32'(bus.if_valid), 32'h1);
    rst_n = 1'b0;
    drive(N, 32'h0, N, N, 32'h0, 32'h0, 4'h0);
    #1;
    chk_quiet("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    preload(10'd4, 32'h11223344);

    // Partial store RMW, error cases, RMW followed by fetch, empty strobe.
    vq.push_back(mk(N,32'h0, Y,Y,32'h10,32'h0000AB00,4'b0010,    N,Y,N,32'h4,32'h0,        N,N,32'h0,        N,N,32'h0));
    vq.push_back(mk(N,32'h0, N,N,32'h0,32'h0,4'h0,               N,N,Y,32'h4,32'h1122AB44, N,N,32'h0,        N,N,32'h0));
    vq.push_back(mk(N,32'h0, N,N,32'h0,32'h0,4'h0,               N,N,N,32'h0,32'h0,        N,N,32'h0,        Y,N,32'h0));
    vq.push_back(mk(N,32'h0, Y,N,32'h1000,32'h0,4'h0,            N,Y,N,32'h0,32'h0,        N,N,32'h0,        N,N,32'h0));
    vq.push_back(mk(N,32'h0, N,N,32'h0,32'h0,4'h0,               N,N,N,32'h0,32'h0,        N,N,32'h0,        Y,Y,32'h0));
    vq.push_back(mk(N,32'h0, Y,Y,32'h2,32'hFFFFFFFF,4'hF,        N,Y,N,32'h0,32'h0,        N,N,32'h0,        N,N,32'h0));
    vq.push_back(mk(N,32'h0, N,N,32'h0,32'h0,4'h0,               N,N,N,32'h0,32'h0,        N,N,32'h0,        Y,Y,32'h0));
    vq.push_back(mk(Y,32'h10, Y,Y,32'h10,32'h99000000,4'b1000,   N,Y,N,32'h4,32'h0,        N,N,32'h0,        N,N,32'h0));
    vq.push_back(mk(Y,32'h10, N,N,32'h0,32'h0,4'h0,              N,N,Y,32'h4,32'h9922AB44, N,N,32'h0,        N,N,32'h0));
    vq.push_back(mk(Y,32'h10, N,N,32'h0,32'h0,4'h0,              Y,N,N,32'h4,32'h0,        N,N,32'h0,        Y,N,32'h0));
    vq.push_back(mk(N,32'h0, N,N,32'h0,32'h0,4'h0,               N,N,N,32'h0,32'h0,        Y,N,32'h9922AB44, N,N,32'h0));
    vq.push_back(mk(N,32'h0, Y,Y,32'h10,32'h12345678,4'h0,       N,Y,N,32'h4,32'h0,        N,N,32'h0,        N,N,32'h0));
    vq.push_back(mk(N,32'h0, Y,N,32'h10,32'h0,4'h0,              N,Y,N,32'h4,32'h0,        N,N,32'h0,        Y,N,32'h0));
    vq.push_back(mk(N,32'h0, N,N,32'h0,32'h0,4'h0,               N,N,N,32'h0,32'h0,        N,N,32'h0,        Y,N,32'h9922AB44));
    vq.push_back(mk(Y,32'h2000, N,N,32'h0,32'h0,4'h0,            Y,N,N,32'h0,32'h0,        N,N,32'h0,        N,N,32'h0));
    vq.push_back(mk(N,32'h0, N,N,32'h0,32'h0,4'h0,               N,N,N,32'h0,32'h0,        Y,Y,32'h0,        N,N,32'h0));
    run_table("rmw_err");

    // Anti-starvation: both held, full stores; IF forced through every fifth grant.
    @(negedge clk);
    drive(Y, 32'h0, Y, Y, 32'h20, 32'hCAFEF00D, 4'hF);
    for (int k = 0; k < 12; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      exp_if = (k == 4) || (k == 9);
      chk($sformatf("streak c%0d if_gnt", k), 32'(bus.if_gnt), 32'(exp_if));
      chk($sformatf("streak c%0d ls_gnt", k), 32'(bus.ls_gnt), 32'(!exp_if));
      chk($sformatf("streak c%0d mem_we", k), 32'(bus.mem_we), 32'(!exp_if));
    end
    @(negedge clk);
    drive(N, 32'h0, N, N, 32'h0, 32'h0, 4'h0);

    // Reset during RMW_WR: write is dropped, memory keeps the old word.
    preload(10'd4, 32'h11223344);
    @(negedge clk);
    drive(N, 32'h0, Y, Y, 32'h10, 32'h0000AB00, 4'b0010);
    #1;
    chk("rmwrst ls_gnt", 32'(bus.ls_gnt), 32'h1);
    @(posedge clk); #1;
    drive(N, 32'h0, N, N, 32'h0, 32'h0, 4'h0);
    chk("rmwrst mem_we in RMW", 32'(bus.mem_we), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_quiet("rmwrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vq.push_back(mk(N,32'h0, Y,N,32'h10,32'h0,4'h0,   N,Y,N,32'h4,32'h0,  N,N,32'h0, N,N,32'h0));
    vq.push_back(mk(N,32'h0, N,N,32'h0,32'h0,4'h0,    N,N,N,32'h0,32'h0,  N,N,32'h0, Y,N,32'h11223344));
    run_table("rmw_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
